// File: rtl/spw_rx_avalon_fifo_pkg.sv
// spw_rx_pkg: register map, bit positions and N-char type shared by the SpaceWire RX buffer
package spw_rx_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_IRQEN = 2'd3;
  localparam int STAT_EMPTY = 16;
  localparam int STAT_FULL = 17;
  localparam int STAT_STALL = 18;
  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_STALL_CLR = 1;
  typedef logic [8:0] spw_nchar_t;
endpackage

// File: rtl/spw_rx_avalon_fifo_sync_fifo.sv
// spw_rx_sync_fifo: generic synchronous FIFO with flush, occupancy level and combinational head
module spw_rx_sync_fifo #(
  parameter int W = 9,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [W-1:0]        wdata,
  output logic [W-1:0]        head,
  output logic [DEPTH_LOG2:0] level,
  output logic                full,
  output logic                empty
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  logic [W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == DEPTH[DEPTH_LOG2:0];
  assign empty = level == '0;
  assign head = mem[rd_ptr];
  assign do_pop = pop & ~flush & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);
  // storage array; a push into a full FIFO with a pop overwrites the slot just read out as head
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  // pointers wrap naturally; flush discards everything and takes precedence over push/pop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + DEPTH_LOG2'(do_push);
      rd_ptr <= rd_ptr + DEPTH_LOG2'(do_pop);
      level <= level + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
endmodule

// File: rtl/spw_rx_avalon_fifo.sv
// spw_rx_avalon_fifo: SpaceWire RX N-char FIFO exposed as an Avalon-MM register slave (optional irq via SPW_RX_IRQ_EN)
module spw_rx_avalon_fifo
  import spw_rx_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        spw_rxvalid,
  input  logic        spw_rxflag,
  input  logic [7:0]  spw_rxdata,
  output logic        spw_rxread
`ifdef SPW_RX_IRQ_EN
  ,
  output logic        irq
`endif
);
  spw_nchar_t head;
  logic [DEPTH_LOG2:0] level;
  logic full, empty, pop, flush, stall_clr, stall_set, stall, irq_en, unused_wd;
  logic [31:0] status, rd_mux;
  assign flush = write & (address == ADDR_CTRL) & writedata[CTRL_FLUSH];
  assign stall_clr = write & (address == ADDR_CTRL) & writedata[CTRL_STALL_CLR];
  assign pop = read & (address == ADDR_DATA) & ~empty;
  assign spw_rxread = spw_rxvalid & (~full | pop) & ~flush;
  assign stall_set = spw_rxvalid & full & ~pop;
  assign unused_wd = ^writedata[31:2];
  spw_rx_sync_fifo #(.W($bits(spw_nchar_t)), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(spw_rxread),
    .pop(pop),
    .flush(flush),
    .wdata({spw_rxflag, spw_rxdata}),
    .head(head),
    .level(level),
    .full(full),
    .empty(empty)
  );
  // read mux; an empty DATA read returns all zeros rather than a stale head
  always_comb begin
    status = '0;
    status[15:0] = 16'(level);
    status[STAT_EMPTY] = empty;
    status[STAT_FULL] = full;
    status[STAT_STALL] = stall;
    rd_mux = address == ADDR_DATA ? (empty ? 32'd0 : {1'b1, 22'b0, head}) :
             address == ADDR_STATUS ? status :
             address == ADDR_IRQEN ? {31'b0, irq_en} : 32'd0;
  end
  // registered read data with one-cycle latency, plus sticky stall where set beats clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      readdata <= '0;
      stall <= 1'b0;
    end else begin
      if (read) readdata <= rd_mux;
      stall <= stall_set | (stall & ~stall_clr);
    end
`ifdef SPW_RX_IRQ_EN
  // interrupt enable register and level-sensitive not-empty interrupt
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (write && address == ADDR_IRQEN) irq_en <= writedata[0];
      irq <= irq_en & ~empty;
    end
`else
  assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_spw_rx_avalon_fifo.sv
// tb_spw_rx_avalon_fifo: directed self-checking bench for the SpaceWire RX Avalon FIFO
module tb_spw_rx_avalon_fifo;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] address = '0;
  logic read = 1'b0, write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic spw_rxvalid = 1'b0, spw_rxflag = 1'b0;
  logic [7:0] spw_rxdata = '0;
  logic spw_rxread;
`ifdef SPW_RX_IRQ_EN
  logic irq;
`endif
  int vectors = 0;
  int errors = 0;

  spw_rx_avalon_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .spw_rxvalid(spw_rxvalid),
    .spw_rxflag(spw_rxflag),
    .spw_rxdata(spw_rxdata),
    .spw_rxread(spw_rxread)
`ifdef SPW_RX_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic push(input logic [8:0] c);
    @(negedge clk);
    {spw_rxflag, spw_rxdata} = c;
    spw_rxvalid = 1'b1;
    @(posedge clk);
    #1 spw_rxvalid = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    read = 1'b1;
    @(posedge clk);
    #1 read = 1'b0;
    d = readdata;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    writedata = d;
    write = 1'b1;
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    repeat (2) @(negedge clk);
    vectors++;
    if (readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_readdata got %h want %h", readdata, 32'd0);
    end
    vectors++;
    if (spw_rxread !== 1'b0) begin
      errors++;
      $display("FAIL reset_rxread got %b want 0", spw_rxread);
    end
    reset_n = 1'b1;
    cpu_read(2'd1, d);
    vectors++;
    if (d !== 32'h0001_0000) begin
      errors++;
      $display("FAIL reset_status got %h want %h", d, 32'h0001_0000);
    end
  endtask

  task automatic test_basic;
    logic [31:0] d;
    logic [31:0] exp [4] = '{32'h8000_0041, 32'h8000_01FF, 32'h8000_0000, 32'h0000_0000};
    push(9'h041);
    push(9'h1FF);
    push(9'h000);
    cpu_read(2'd1, d);
    vectors++;
    if (d !== 32'h0000_0003) begin
      errors++;
      $display("FAIL basic_status got %h want %h", d, 32'h3);
    end
    for (int i = 0; i < 4; i++) begin
      cpu_read(2'd0, d);
      vectors++;
      if (d !== exp[i]) begin
        errors++;
        $display("FAIL basic_data%0d got %h want %h", i, d, exp[i]);
      end
    end
  endtask

  task automatic test_fill;
    logic [31:0] d;
    int pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      spw_rxflag = 1'b0;
      spw_rxdata = 8'(i);
      spw_rxvalid = 1'b1;
      #1 if (spw_rxread) pulses++;
    end
    @(negedge clk);
    spw_rxvalid = 1'b0;
    vectors++;
    if (pulses != 16) begin
      errors++;
      $display("FAIL fill_pulses got %0d want 16", pulses);
    end
    cpu_read(2'd1, d);
    vectors++;
    if (d !== 32'h0006_0010) begin
      errors++;
      $display("FAIL fill_status got %h want %h", d, 32'h0006_0010);
    end
    cpu_write(2'd2, 32'h2);
    cpu_read(2'd1, d);
    vectors++;
    if (d !== 32'h0002_0010) begin
      errors++;
      $display("FAIL stall_clear got %h want %h", d, 32'h0002_0010);
    end
  endtask

  task automatic test_full_pop;
    logic [31:0] d;
    @(negedge clk);
    {spw_rxflag, spw_rxdata} = 9'h0AA;
    spw_rxvalid = 1'b1;
    address = 2'd0;
    read = 1'b1;
    #1;
    vectors++;
    if (spw_rxread !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_rxread got %b want 1", spw_rxread);
    end
    @(posedge clk);
    #1 read = 1'b0;
    spw_rxvalid = 1'b0;
    vectors++;
    if (readdata !== 32'h8000_0000) begin
      errors++;
      $display("FAIL fullpop_head got %h want %h", readdata, 32'h8000_0000);
    end
    cpu_read(2'd1, d);
    vectors++;
    if (d !== 32'h0002_0010) begin
      errors++;
      $display("FAIL fullpop_status got %h want %h", d, 32'h0002_0010);
    end
    for (int i = 1; i <= 16; i++) begin
      cpu_read(2'd0, d);
      vectors++;
      if (d !== (i == 16 ? 32'h8000_00AA : 32'h8000_0000 | 32'(i))) begin
        errors++;
        $display("FAIL fullpop_order%0d got %h want %h", i, d, i == 16 ? 32'h8000_00AA : 32'h8000_0000 | 32'(i));
      end
    end
    cpu_read(2'd1, d);
    vectors++;
    if (d !== 32'h0001_0000) begin
      errors++;
      $display("FAIL fullpop_drained got %h want %h", d, 32'h0001_0000);
    end
  endtask

  task automatic test_flush;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) push(9'(8'h30 + i));
    cpu_read(2'd1, d);
    vectors++;
    if (d !== 32'h0000_0005) begin
      errors++;
      $display("FAIL flush_pre got %h want %h", d, 32'h5);
    end
    @(negedge clk);
    address = 2'd2;
    writedata = 32'h1;
    write = 1'b1;
    {spw_rxflag, spw_rxdata} = 9'h077;
    spw_rxvalid = 1'b1;
    #1;
    vectors++;
    if (spw_rxread !== 1'b0) begin
      errors++;
      $display("FAIL flush_rxread got %b want 0", spw_rxread);
    end
    @(posedge clk);
    #1 write = 1'b0;
    spw_rxvalid = 1'b0;
    cpu_read(2'd1, d);
    vectors++;
    if (d !== 32'h0001_0000) begin
      errors++;
      $display("FAIL flush_post got %h want %h", d, 32'h0001_0000);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) push(9'(8'h10 + i));
    cpu_read(2'd0, d);
    vectors++;
    if (d !== 32'h8000_0010) begin
      errors++;
      $display("FAIL arst_pre got %h want %h", d, 32'h8000_0010);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (readdata !== 32'd0) begin
      errors++;
      $display("FAIL arst_readdata got %h want 0", readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cpu_read(2'd1, d);
    vectors++;
    if (d !== 32'h0001_0000) begin
      errors++;
      $display("FAIL arst_status got %h want %h", d, 32'h0001_0000);
    end
    push(9'h155);
    cpu_read(2'd0, d);
    vectors++;
    if (d !== 32'h8000_0155) begin
      errors++;
      $display("FAIL arst_push got %h want %h", d, 32'h8000_0155);
    end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    cpu_write(2'd3, 32'h1);
    cpu_read(2'd3, d);
`ifdef SPW_RX_IRQ_EN
    vectors++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL irqen_read got %h want 1", d);
    end
    push(9'h023);
    @(posedge clk);
    #1;
    vectors++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set got %b want 1", irq);
    end
    cpu_read(2'd0, d);
    @(posedge clk);
    #1;
    vectors++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear got %b want 0", irq);
    end
`else
    vectors++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL addr3_read got %h want 0", d);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_pop();
    test_flush();
    test_async_reset();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
